// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor family.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : serial_sub_pkg

// File: rtl/fullsubtractor.sv
// One-bit combinational full subtractor: a - b - bin.
module fullsubtractor (
   input  logic i_a,
   input  logic i_b,
   input  logic i_bin,
   output logic o_d,
   output logic o_bout
);

   assign o_d    = i_a ^ i_b ^ i_bin;
   assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule : fullsubtractor

// File: rtl/serial_sub4.sv
// Bit-serial subtractor: one full-subtractor cell, LSB first, WIDTH cycles per result.
module serial_sub4
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic [WIDTH-1:0] D,
   output logic             Bout,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           r_state;
   state_t           w_next;
   logic             w_load;
   logic             w_last;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_borrow;
   logic [WIDTH-1:0] r_d;
   logic             r_bout;
   logic             r_busy;
   logic             r_done;
   logic             w_d;
   logic             w_bout;

   fullsubtractor u_cell (
      .i_a    (r_a[0]),
      .i_b    (r_b[0]),
      .i_bin  (r_borrow),
      .o_d    (w_d),
      .o_bout (w_bout)
   );

   assign w_last = (r_cnt == CW'(WIDTH - 1));

   // State register; busy/done are registered decodes of the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next == RUN);
         r_done  <= (w_next == DONE);
      end
   end

   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_next = RUN;
               w_load = 1'b1;
            end
         end
         RUN: begin
            if (w_last) w_next = DONE;
         end
         DONE: begin
            if (start) begin
               w_next = RUN;
               w_load = 1'b1;
            end else begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // Operand shifters, borrow chain, bit counter and result registers.
   // Bout is captured with the last bit so it is valid alongside done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
         r_d      <= '0;
         r_bout   <= 1'b0;
      end else if (w_load) begin
         r_a      <= A;
         r_b      <= B;
         r_borrow <= Bin;
         r_cnt    <= '0;
      end else if (r_state == RUN) begin
         r_a        <= r_a >> 1;
         r_b        <= r_b >> 1;
         r_borrow   <= w_bout;
         r_d[r_cnt] <= w_d;
         if (w_last) r_bout <= w_bout;
         else        r_cnt  <= r_cnt + CW'(1);
      end
   end

   assign D    = r_d;
   assign Bout = r_bout;
   assign busy = r_busy;
   assign done = r_done;

endmodule : serial_sub4

// File: tb/tb_serial_sub4.sv
// Randomized self-checking bench for serial_sub4 against an arithmetic reference.
module tb_serial_sub4;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] A;
   logic [3:0] B;
   logic       Bin;
   logic [3:0] D;
   logic       Bout;
   logic       busy;
   logic       done;

   int n_total;
   int n_pass;

   serial_sub4 #(.WIDTH(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .Bin   (Bin),
      .D     (D),
      .Bout  (Bout),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout, need $finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference: {Bout, D} from plain integer arithmetic.
   function automatic logic [4:0] ref_sub(input int a, input int b, input int bin);
      int diff;
      logic [4:0] r;
      diff = a - b - bin;
      r[3:0] = 4'(diff & 15);
      r[4]   = (a < b + bin);
      return r;
   endfunction

   // Waits (bounded) for done at negedges; cyc = negedges seen before done.
   task automatic wait_done(output int cyc, output int nb);
      bit found;
      found = 1'b0;
      cyc = 99;
      nb = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (done) begin
            cyc = i;
            found = 1'b1;
         end else if (busy) begin
            nb++;
         end
      end
   endtask

   // Called at #1 after a posedge with the DUT idle; returns at #1 after the edge leaving DONE.
   task automatic do_sub(input logic [3:0] a, input logic [3:0] b, input logic bin,
                         input logic [3:0] ed, input logic eb, input string tag);
      int cyc, nb;
      start = 1'b1; A = a; B = b; Bin = bin;
      @(posedge clk); #1;
      start = 1'b0; A = 4'($urandom); B = 4'($urandom); Bin = 1'($urandom);
      wait_done(cyc, nb);
      check({tag, "_lat"}, 32'(cyc), 32'd4);
      check({tag, "_busy"}, 32'(nb), 32'd4);
      check({tag, "_D"}, 32'(D), 32'(ed));
      check({tag, "_Bout"}, 32'(Bout), 32'(eb));
      @(posedge clk); #1;
   endtask

   initial begin
      int cyc, nb, ndone;
      int order[512];
      logic [4:0] r;

      n_total = 0; n_pass = 0;
      rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
      #2;
      check("rst_D", 32'(D), 32'd0);
      check("rst_Bout", 32'(Bout), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      do_sub(4'd9, 4'd3, 1'b0, 4'd6, 1'b0, "s9m3");
      @(negedge clk);
      check("idle_done", 32'(done), 32'd0);
      check("idle_D_hold", 32'(D), 32'd6);
      @(posedge clk); #1;
      do_sub(4'd0, 4'd0, 1'b1, 4'hF, 1'b1, "s0m0b1");
      do_sub(4'd3, 4'd9, 1'b0, 4'hA, 1'b1, "s3m9");

      // Asynchronous reset in the middle of a run.
      start = 1'b1; A = 4'd9; B = 4'd3; Bin = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("arst_D", 32'(D), 32'd0);
      check("arst_Bout", 32'(Bout), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      ndone = 0;
      repeat (3) begin @(negedge clk); if (done) ndone++; end
      @(posedge clk); #1 rst = 1'b0;
      repeat (6) begin @(negedge clk); if (done || busy) ndone++; end
      check("arst_nodone", 32'(ndone), 32'd0);
      @(posedge clk); #1;
      do_sub(4'd12, 4'd7, 1'b0, 4'd5, 1'b0, "s12m7");

      // start held high: back-to-back results.
      start = 1'b1; A = 4'd5; B = 4'd2; Bin = 1'b0;
      @(posedge clk); #1;
      A = 4'd15; B = 4'd15;
      wait_done(cyc, nb);
      check("b2b1_lat", 32'(cyc), 32'd4);
      check("b2b1_D", 32'(D), 32'd3);
      check("b2b1_Bout", 32'(Bout), 32'd0);
      @(posedge clk); #1;
      start = 1'b0; A = 4'($urandom); B = 4'($urandom); Bin = 1'b1;
      wait_done(cyc, nb);
      check("b2b2_period", 32'(cyc), 32'd4);
      check("b2b2_D", 32'(D), 32'd0);
      check("b2b2_Bout", 32'(Bout), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("b2b_idle_done", 32'(done), 32'd0);
      check("b2b_idle_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;

      // start pulsed during RUN must be ignored.
      start = 1'b1; A = 4'd9; B = 4'd3; Bin = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; A = 4'd1; B = 4'd7; Bin = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(cyc, nb);
      check("ign_lat", 32'(cyc), 32'd2);
      check("ign_D", 32'(D), 32'd6);
      check("ign_Bout", 32'(Bout), 32'd0);
      @(posedge clk); #1;
      ndone = 0;
      repeat (10) begin @(negedge clk); if (done || busy) ndone++; end
      check("ign_noextra", 32'(ndone), 32'd0);
      @(posedge clk); #1;

      // All 512 operand combinations in shuffled order.
      for (int i = 0; i < 512; i++) order[i] = i;
      for (int i = 511; i > 0; i--) begin
         int j, t;
         j = int'($urandom_range(i, 0));
         t = order[i]; order[i] = order[j]; order[j] = t;
      end
      for (int i = 0; i < 512; i++) begin
         int a, b, bi;
         a  = order[i] & 15;
         b  = (order[i] >> 4) & 15;
         bi = (order[i] >> 8) & 1;
         r = ref_sub(a, b, bi);
         do_sub(4'(a), 4'(b), 1'(bi), r[3:0], r[4], $sformatf("sw%0d_%0d_%0d", a, b, bi));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_serial_sub4
